// File: rtl/calendar_date_if.sv
// ---------------------------------------------------------------------------
// calendar_date_if
// Bundles the control, load/adjust and display signals of the calendar
// counter so that set-mode logic and the display path can share one port.
//   master : drives day_tick, load + ld_* fields, adj + adj_field, enable;
//            observes the current date fields, databus and the event pulses
//   slave  : the calendar counter itself (the opposite directions)
// ---------------------------------------------------------------------------
interface calendar_date_if #(
    parameter int YEAR_W = 12
) ();
    logic                  day_tick;
    logic                  load;
    logic [4:0]            ld_date;
    logic [3:0]            ld_month;
    logic [YEAR_W-1:0]     ld_year;
    logic [2:0]            ld_wday;
    logic                  adj;
    logic [1:0]            adj_field;
    logic                  enable;

    logic [4:0]            date;
    logic [3:0]            month;
    logic [YEAR_W-1:0]     year;
    logic [2:0]            wday;
    logic [12+YEAR_W-1:0]  databus;
    logic                  month_carry;
    logic                  year_carry;
    logic                  year_wrap;
    logic                  load_err;

    modport master (
        output day_tick, load, ld_date, ld_month, ld_year, ld_wday,
               adj, adj_field, enable,
        input  date, month, year, wday, databus,
               month_carry, year_carry, year_wrap, load_err
    );

    modport slave (
        input  day_tick, load, ld_date, ld_month, ld_year, ld_wday,
               adj, adj_field, enable,
        output date, month, year, wday, databus,
               month_carry, year_carry, year_wrap, load_err
    );
endinterface

// File: rtl/calendar_date.sv
// ---------------------------------------------------------------------------
// calendar_date
// Calendar counter for the digital clock: date-of-month, month, year and
// weekday, advanced by the day carry of the hour counter, with validated
// parallel load and per-field adjust for the set-mode buttons.
// Ports:
//   clk      : system clock, rising edge
//   clear_n  : asynchronous active-low clear to the reset epoch
//   bus      : calendar_date_if.slave (strobes, load/adjust fields, enable,
//              date fields, enable-gated databus, one-cycle event pulses)
// Edge priority is load > adj > day_tick.
// ---------------------------------------------------------------------------
module calendar_date #(
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2000,
    parameter int RESET_WDAY = 1,
    parameter int LEAP_MODE  = 2
) (
    input  logic                   clk,
    input  logic                   clear_n,
    calendar_date_if.slave         bus
);

    localparam logic [YEAR_W-1:0] YEAR_MAX = {YEAR_W{1'b1}};
    localparam logic [YEAR_W-1:0] YEAR_ONE = {{(YEAR_W-1){1'b0}}, 1'b1};

    // Leap-year rule selected by LEAP_MODE (0 none, 1 every 4th, 2 Gregorian)
    function automatic logic f_is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yy;
        logic        leap;
        yy = 32'(y);
        if (LEAP_MODE == 32'sd0) begin
            leap = 1'b0;
        end else if (LEAP_MODE == 32'sd1) begin
            leap = (yy[1:0] == 2'b00);
        end else begin
            leap = (yy[1:0] == 2'b00) &&
                   (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
        end
        return leap;
    endfunction

    // Days in a month; an illegal month yields 0 so no date can validate
    function automatic logic [4:0] f_mlen(input logic [3:0] m,
                                          input logic [YEAR_W-1:0] y);
        logic [4:0] len;
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
            4'd2:    len = f_is_leap(y) ? 5'd29 : 5'd28;
            default: len = 5'd0;
        endcase
        return len;
    endfunction

    logic [4:0]        r_date;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [2:0]        r_wday;
    logic              r_month_carry;
    logic              r_year_carry;
    logic              r_year_wrap;
    logic              r_load_err;

    logic [4:0]        w_date;
    logic [3:0]        w_month;
    logic [YEAR_W-1:0] w_year;
    logic [2:0]        w_wday;
    logic              w_month_carry;
    logic              w_year_carry;
    logic              w_year_wrap;
    logic              w_load_err;

    logic [4:0]        w_cur_mlen;
    logic [3:0]        w_next_month;
    logic [YEAR_W-1:0] w_next_year;
    logic [2:0]        w_next_wday;
    logic [4:0]        w_mlen_nm;
    logic [4:0]        w_mlen_ny;
    logic              w_ld_ok;

    assign w_cur_mlen   = f_mlen(r_month, r_year);
    assign w_next_month = (r_month == 4'd12) ? 4'd1 : (r_month + 4'd1);
    assign w_next_year  = r_year + YEAR_ONE;
    assign w_next_wday  = (r_wday == 3'd7) ? 3'd1 : (r_wday + 3'd1);
    // Month lengths after a month or year adjust, used to clamp the date
    assign w_mlen_nm    = f_mlen(w_next_month, r_year);
    assign w_mlen_ny    = f_mlen(r_month, w_next_year);
    // f_mlen returns 0 for months 0/13-15, so the date test also rejects them
    assign w_ld_ok      = (bus.ld_date  != 5'd0) &&
                          (bus.ld_date  <= f_mlen(bus.ld_month, bus.ld_year)) &&
                          (bus.ld_wday  != 3'd0);

    // Next-state selection: load, then adjust, then day advance
    always_comb begin
        w_date        = r_date;
        w_month       = r_month;
        w_year        = r_year;
        w_wday        = r_wday;
        w_month_carry = 1'b0;
        w_year_carry  = 1'b0;
        w_year_wrap   = 1'b0;
        w_load_err    = 1'b0;
        if (bus.load) begin
            if (w_ld_ok) begin
                w_date  = bus.ld_date;
                w_month = bus.ld_month;
                w_year  = bus.ld_year;
                w_wday  = bus.ld_wday;
            end else begin
                w_load_err = 1'b1;
            end
        end else if (bus.adj) begin
            case (bus.adj_field)
                2'b01: w_date = (r_date >= w_cur_mlen) ? 5'd1 : (r_date + 5'd1);
                2'b10: begin
                    w_month = w_next_month;
                    w_date  = (r_date > w_mlen_nm) ? w_mlen_nm : r_date;
                end
                2'b11: begin
                    w_year = w_next_year;
                    w_date = (r_date > w_mlen_ny) ? w_mlen_ny : r_date;
                end
                default: w_date = r_date;
            endcase
        end else if (bus.day_tick) begin
            w_wday = w_next_wday;
            if (r_date < w_cur_mlen) begin
                w_date = r_date + 5'd1;
            end else begin
                w_date        = 5'd1;
                w_month_carry = 1'b1;
                if (r_month < 4'd12) begin
                    w_month = r_month + 4'd1;
                end else begin
                    w_month      = 4'd1;
                    w_year_carry = 1'b1;
                    w_year       = w_next_year;
                    w_year_wrap  = (r_year == YEAR_MAX);
                end
            end
        end else begin
            w_date = r_date;
        end
    end

    // State and event-pulse registers with asynchronous clear
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_date        <= 5'd1;
            r_month       <= 4'd1;
            r_year        <= YEAR_W'(RESET_YEAR);
            r_wday        <= 3'(RESET_WDAY);
            r_month_carry <= 1'b0;
            r_year_carry  <= 1'b0;
            r_year_wrap   <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_date        <= w_date;
            r_month       <= w_month;
            r_year        <= w_year;
            r_wday        <= w_wday;
            r_month_carry <= w_month_carry;
            r_year_carry  <= w_year_carry;
            r_year_wrap   <= w_year_wrap;
            r_load_err    <= w_load_err;
        end
    end

    assign bus.date        = r_date;
    assign bus.month       = r_month;
    assign bus.year        = r_year;
    assign bus.wday        = r_wday;
    assign bus.month_carry = r_month_carry;
    assign bus.year_carry  = r_year_carry;
    assign bus.year_wrap   = r_year_wrap;
    assign bus.load_err    = r_load_err;
    assign bus.databus     = {r_wday, r_month, r_date, r_year} & {(12+YEAR_W){bus.enable}};

endmodule

// File: tb/tb_calendar_date.sv
// ---------------------------------------------------------------------------
// tb_calendar_date
// Directed vectors against three calendar_date instances that differ only
// in LEAP_MODE (2, 1, 0); all share the same stimulus.
// ---------------------------------------------------------------------------
module tb_calendar_date;

    localparam int YW = 12;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          day_tick, load, adj, enable;
    logic [4:0]    ld_date;
    logic [3:0]    ld_month;
    logic [YW-1:0] ld_year;
    logic [2:0]    ld_wday;
    logic [1:0]    adj_field;

    int n_vec = 0;
    int n_err = 0;

    calendar_date_if #(.YEAR_W(YW)) if2 ();
    calendar_date_if #(.YEAR_W(YW)) if1 ();
    calendar_date_if #(.YEAR_W(YW)) if0 ();

    // Same stimulus into every instance
    assign if2.day_tick = day_tick;  assign if1.day_tick = day_tick;  assign if0.day_tick = day_tick;
    assign if2.load = load;          assign if1.load = load;          assign if0.load = load;
    assign if2.ld_date = ld_date;    assign if1.ld_date = ld_date;    assign if0.ld_date = ld_date;
    assign if2.ld_month = ld_month;  assign if1.ld_month = ld_month;  assign if0.ld_month = ld_month;
    assign if2.ld_year = ld_year;    assign if1.ld_year = ld_year;    assign if0.ld_year = ld_year;
    assign if2.ld_wday = ld_wday;    assign if1.ld_wday = ld_wday;    assign if0.ld_wday = ld_wday;
    assign if2.adj = adj;            assign if1.adj = adj;            assign if0.adj = adj;
    assign if2.adj_field = adj_field; assign if1.adj_field = adj_field; assign if0.adj_field = adj_field;
    assign if2.enable = enable;      assign if1.enable = enable;      assign if0.enable = enable;

    calendar_date #(.YEAR_W(YW), .RESET_YEAR(2000), .RESET_WDAY(1), .LEAP_MODE(2))
        u_dut2 (.clk(clk), .clear_n(clear_n), .bus(if2));
    calendar_date #(.YEAR_W(YW), .RESET_YEAR(2000), .RESET_WDAY(1), .LEAP_MODE(1))
        u_dut1 (.clk(clk), .clear_n(clear_n), .bus(if1));
    calendar_date #(.YEAR_W(YW), .RESET_YEAR(2000), .RESET_WDAY(1), .LEAP_MODE(0))
        u_dut0 (.clk(clk), .clear_n(clear_n), .bus(if0));

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Date/month/year/wday of the Gregorian instance
    task automatic chk_state(input string tag, input int d, input int m, input int y, input int w);
        chk({tag, ".date"},  32'(if2.date),  32'(d));
        chk({tag, ".month"}, 32'(if2.month), 32'(m));
        chk({tag, ".year"},  32'(if2.year),  32'(y));
        chk({tag, ".wday"},  32'(if2.wday),  32'(w));
    endtask

    // {month_carry, year_carry, year_wrap, load_err} of the Gregorian instance
    task automatic chk_pulses(input string tag, input logic [3:0] exp);
        chk({tag, ".pulses"},
            {28'd0, if2.month_carry, if2.year_carry, if2.year_wrap, if2.load_err},
            {28'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d, input int m, input int y, input int w);
        load = 1'b1; ld_date = 5'(d); ld_month = 4'(m); ld_year = YW'(y); ld_wday = 3'(w);
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
    endtask

    task automatic do_adj(input logic [1:0] f);
        adj = 1'b1; adj_field = f;
        step();
        adj = 1'b0; adj_field = 2'b00;
    endtask

    initial begin
        clear_n = 1'b0; day_tick = 1'b0; load = 1'b0; adj = 1'b0; enable = 1'b0;
        ld_date = 5'd0; ld_month = 4'd0; ld_year = '0; ld_wday = 3'd0; adj_field = 2'b00;
        #12;
        chk_state("rst", 1, 1, 2000, 1);
        chk_pulses("rst", 4'b0000);
        chk("rst.bus_off", 32'(if2.databus), 32'd0);
        clear_n = 1'b1;
        step(); step();
        chk_state("idle", 1, 1, 2000, 1);
        enable = 1'b1;
        #1;
        chk("bus_on", 32'(if2.databus), {8'd0, 3'd1, 4'd1, 5'd1, 12'd2000});

        // Leap 2000 under Gregorian
        do_load(28, 2, 2000, 1);
        chk_state("ld2000", 28, 2, 2000, 1);
        do_tick();
        chk_state("t1_2000", 29, 2, 2000, 2);
        chk_pulses("t1_2000", 4'b0000);
        do_tick();
        chk_state("t2_2000", 1, 3, 2000, 3);
        chk_pulses("t2_2000", 4'b1000);
        step();
        chk_pulses("t2_2000_after", 4'b0000);
        chk("bus_mar", 32'(if2.databus), {8'd0, 3'd3, 4'd3, 5'd1, 12'd2000});

        // 1900: not leap under Gregorian or mode 0, leap under mode 1
        do_load(28, 2, 1900, 4);
        do_tick();
        chk_state("g1900", 1, 3, 1900, 5);
        chk("m1_1900.date",  32'(if1.date),  32'd29);
        chk("m1_1900.month", 32'(if1.month), 32'd2);
        chk("m1_1900.mc",    32'(if1.month_carry), 32'd0);
        chk("m0_1900.date",  32'(if0.date),  32'd1);
        chk("m0_1900.month", 32'(if0.month), 32'd3);
        // 2000 under mode 0 has no Feb 29
        do_load(28, 2, 2000, 1);
        do_tick();
        chk("m0_2000.month", 32'(if0.month), 32'd3);

        // Year wrap from 4095
        do_load(31, 12, 4095, 5);
        do_tick();
        chk_state("wrap", 1, 1, 0, 6);
        chk_pulses("wrap", 4'b1110);
        step();
        chk_pulses("wrap_after", 4'b0000);

        // Rejected loads
        do_load(31, 4, 2021, 1);
        chk_state("bad_apr31", 1, 1, 0, 6);
        chk_pulses("bad_apr31", 4'b0001);
        step();
        chk_pulses("bad_apr31_after", 4'b0000);
        do_load(10, 5, 2021, 0);
        chk_state("bad_wday0", 1, 1, 0, 6);
        chk_pulses("bad_wday0", 4'b0001);
        do_load(1, 13, 2021, 1);
        chk_pulses("bad_month13", 4'b0001);
        do_load(29, 2, 2021, 1);
        chk_state("bad_feb29", 1, 1, 0, 6);

        // Adjust
        do_load(31, 1, 2021, 2);
        do_adj(2'b10);
        chk_state("adj_month", 28, 2, 2021, 2);
        chk_pulses("adj_month", 4'b0000);
        do_adj(2'b01);
        chk_state("adj_date", 1, 2, 2021, 2);
        chk_pulses("adj_date", 4'b0000);
        do_adj(2'b00);
        chk_state("adj_nop", 1, 2, 2021, 2);
        do_load(29, 2, 2024, 4);
        do_adj(2'b11);
        chk_state("adj_year", 28, 2, 2025, 4);
        do_load(5, 12, 4095, 3);
        do_adj(2'b11);
        chk_state("adj_year_wrap", 5, 12, 0, 3);
        chk_pulses("adj_year_wrap", 4'b0000);
        do_load(10, 12, 2021, 3);
        do_adj(2'b10);
        chk_state("adj_dec", 10, 1, 2021, 3);

        // Priority
        load = 1'b1; adj = 1'b1; adj_field = 2'b01; day_tick = 1'b1;
        ld_date = 5'd15; ld_month = 4'd6; ld_year = YW'(2022); ld_wday = 3'd3;
        step();
        load = 1'b0;
        chk_state("prio_load", 15, 6, 2022, 3);
        step();
        adj = 1'b0; day_tick = 1'b0; adj_field = 2'b00;
        chk_state("prio_adj", 16, 6, 2022, 3);

        // Back-to-back ticks
        do_load(30, 1, 2021, 7);
        day_tick = 1'b1;
        step();
        chk_state("b2b_1", 31, 1, 2021, 1);
        step();
        day_tick = 1'b0;
        chk_state("b2b_2", 1, 2, 2021, 2);
        chk_pulses("b2b_2", 4'b1000);

        // Clear while pulses are up
        do_load(31, 12, 2030, 2);
        do_tick();
        chk_pulses("pre_clr", 4'b1100);
        #2;
        clear_n = 1'b0;
        #1;
        chk_state("clr", 1, 1, 2000, 1);
        chk_pulses("clr", 4'b0000);
        #3;
        clear_n = 1'b1;
        step();
        chk_state("clr_after", 1, 1, 2000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
